// File: rtl/bin_dec_pkg.sv
// Shared definitions for the binary-to-one-hot LED decoder/sequencer:
// mode encodings and the bounce direction type.
package bin_dec_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/bin_decoder_sequencer_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with an active-high enable;
// the output is all-zero when disabled.
module bin_onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] onehot
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/bin_decoder_sequencer.sv
// Registered binary-to-one-hot LED driver with direct select and a prescaled
// up / down / bounce auto-scan sequencer with synchronous index load.
module bin_decoder_sequencer
    import bin_dec_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DIV_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  ld,
    input  logic [SEL_W-1:0]      a,
    output logic [(1<<SEL_W)-1:0] led,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;

    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    dir_t             dir_q,  dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [N-1:0]     led_q,  led_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        wrap_d = 1'b0;

        if (!en) begin
            // Frozen: only the LED bank blanks.
        end else if (mode == MODE_DIRECT) begin
            idx_d  = a;
            cnt_d  = '0;
            mode_d = mode;
        end else if (mode != mode_q) begin
            // Mode switch restarts the prescaler and never steps in the same cycle.
            cnt_d  = '0;
            mode_d = mode;
            if (mode == MODE_BOUNCE) begin
                dir_d = DIR_UP;
            end
            if (ld) begin
                idx_d = a;
            end
        end else if (ld) begin
            idx_d = a;
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            case (mode)
                MODE_UP: begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end
                MODE_DOWN: begin
                    idx_d  = idx_q - SEL_W'(1);
                    wrap_d = (idx_q == '0);
                end
                default: begin
                    if (dir_q == DIR_UP) begin
                        if (idx_q == IDX_MAX) begin
                            dir_d = DIR_DOWN;
                            idx_d = IDX_MAX - SEL_W'(1);
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                    end else begin
                        if (idx_q == '0) begin
                            dir_d  = DIR_UP;
                            idx_d  = SEL_W'(1);
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q - SEL_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    bin_onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en     (en),
        .sel    (idx_d),
        .onehot (led_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_DIRECT;
            led_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            wrap_q <= wrap_d;
        end
    end

    assign led  = led_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_decoder_sequencer.sv
// Directed bench: four decoder instances (different prescaler / width) share
// one stimulus; each phase checks only the instance it is written for.
module tb_bin_decoder_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       ld = 1'b0;
    logic [3:0] a = 4'd0;

    logic [15:0] led3, led1, led2;
    logic [3:0]  idx3, idx1, idx2;
    logic        wrap3, wrap1, wrap2;
    logic [1:0]  leds;
    logic        idxs, wraps;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_decoder_sequencer #(.SEL_W(4), .DIV_MAX(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .a(a),
        .led(led3), .idx(idx3), .wrap(wrap3));

    bin_decoder_sequencer #(.SEL_W(4), .DIV_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .a(a),
        .led(led1), .idx(idx1), .wrap(wrap1));

    bin_decoder_sequencer #(.SEL_W(4), .DIV_MAX(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .a(a),
        .led(led2), .idx(idx2), .wrap(wrap2));

    bin_decoder_sequencer #(.SEL_W(1), .DIV_MAX(1)) duts (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .a(a[0:0]),
        .led(leds), .idx(idxs), .wrap(wraps));

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [1:0]  mode;
        logic        ld;
        logic [3:0]  a;
        logic [15:0] led;
        logic [3:0]  idx;
        logic        wrap;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, then sample 1 ns later.
    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic [3:0] av);
        rst_n = r;
        en    = e;
        mode  = m;
        ld    = l;
        a     = av;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx[9];
        logic exp_wrap[9];

        vecs[0] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'd5,  16'h0000, 4'd0,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'd5,  16'h0000, 4'd0,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'b00, 1'b0, 4'd9,  16'h0200, 4'd9,  1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b00, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'b00, 1'b0, 4'd15, 16'h8000, 4'd15, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 4'd3,  16'h0000, 4'd15, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 2'b00, 1'b0, 4'd3,  16'h0008, 4'd3,  1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'b00, 1'b1, 4'd7,  16'h0080, 4'd7,  1'b0};
        vecs[8] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'd12, 16'h0000, 4'd0,  1'b0};

        #2;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].ld, vecs[i].a);
            check($sformatf("vec%0d_led", i),  64'(led3),  64'(vecs[i].led));
            check($sformatf("vec%0d_idx", i),  64'(idx3),  64'(vecs[i].idx));
            check($sformatf("vec%0d_wrap", i), 64'(wrap3), 64'(vecs[i].wrap));
        end

        // Scan up, DIV_MAX=3: mode change + load of 14, then steps every 3 cycles.
        drive(1'b1, 1'b1, 2'b01, 1'b1, 4'd14);
        check("up_load_idx", 64'(idx3), 64'd14);
        check("up_load_led", 64'(led3), 64'h4000);
        exp_idx  = '{14, 14, 15, 15, 15, 0, 0, 0, 1};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
            check($sformatf("up_c%0d_idx", i),  64'(idx3),  64'(exp_idx[i]));
            check($sformatf("up_c%0d_wrap", i), 64'(wrap3), 64'(exp_wrap[i]));
            if (i == 5) check("up_wrap_led", 64'(led3), 64'h0001);
        end

        // Blanking at idx=5 with the prescaler part-way through its period.
        drive(1'b1, 1'b1, 2'b01, 1'b1, 4'd5);
        check("blank_load_idx", 64'(idx3), 64'd5);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'b01, 1'b0, 4'd0);
            check($sformatf("blank%0d_led", i), 64'(led3), 64'h0);
            check($sformatf("blank%0d_idx", i), 64'(idx3), 64'd5);
        end
        drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
        check("unblank_idx", 64'(idx3), 64'd5);
        check("unblank_led", 64'(led3), 64'h0020);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 4'd0);
        check("unblank_step_idx", 64'(idx3), 64'd6);
        check("unblank_step_led", 64'(led3), 64'h0040);

        // Scan down, DIV_MAX=2: wrap from 0, then ld colliding with a tick.
        drive(1'b0, 1'b1, 2'b10, 1'b0, 4'd0);
        check("dn_rst_idx", 64'(idx2), 64'd0);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("dn_modechg_idx", 64'(idx2), 64'd0);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("dn_cnt_idx", 64'(idx2), 64'd0);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("dn_wrap_idx", 64'(idx2), 64'd15);
        check("dn_wrap_pulse", 64'(wrap2), 64'd1);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("dn_wrap_end", 64'(wrap2), 64'd0);
        drive(1'b1, 1'b1, 2'b10, 1'b1, 4'd3);
        check("ldtick_idx", 64'(idx2), 64'd3);
        check("ldtick_wrap", 64'(wrap2), 64'd0);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("ldtick_hold_idx", 64'(idx2), 64'd3);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 4'd0);
        check("ldtick_step_idx", 64'(idx2), 64'd2);

        // Bounce, DIV_MAX=1 (plus the SEL_W=1 instance alternating 0,1).
        drive(1'b0, 1'b1, 2'b11, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 2'b11, 1'b1, 4'd13);
        check("bn_load_idx", 64'(idx1), 64'd13);
        check("bn1_load_idx", 64'(idxs), 64'd1);
        exp_idx = '{14, 15, 14, 13, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
            check($sformatf("bn_hi%0d_idx", i),  64'(idx1),  64'(exp_idx[i]));
            check($sformatf("bn_hi%0d_wrap", i), 64'(wrap1), 64'd0);
            check($sformatf("bn1_%0d_idx", i),   64'(idxs),  64'(i[0] ? 1 : 0));
            check($sformatf("bn1_%0d_wrap", i),  64'(wraps), 64'(i[0] ? 1 : 0));
            check($sformatf("bn1_%0d_led", i),   64'(leds),  64'(i[0] ? 2 : 1));
        end
        drive(1'b1, 1'b1, 2'b11, 1'b1, 4'd2);
        check("bn_ld2_idx", 64'(idx1), 64'd2);
        exp_idx  = '{1, 0, 1, 2, 0, 0, 0, 0, 0};
        exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
            check($sformatf("bn_lo%0d_idx", i),  64'(idx1),  64'(exp_idx[i]));
            check($sformatf("bn_lo%0d_wrap", i), 64'(wrap1), 64'(exp_wrap[i]));
        end

        // Reset mid-bounce at idx=8 heading down.
        drive(1'b1, 1'b1, 2'b11, 1'b1, 4'd15);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
        check("rm_turn_idx", 64'(idx1), 64'd14);
        drive(1'b1, 1'b1, 2'b11, 1'b1, 4'd9);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
        check("rm_pre_idx", 64'(idx1), 64'd8);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 4'd0);
        check("rm_rst_led", 64'(led1), 64'h0);
        check("rm_rst_idx", 64'(idx1), 64'd0);
        check("rm_rst_wrap", 64'(wrap1), 64'd0);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
        check("rm_modechg_idx", 64'(idx1), 64'd0);
        check("rm_modechg_led", 64'(led1), 64'h0001);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0);
        check("rm_step_idx", 64'(idx1), 64'd1);
        check("rm_step_wrap", 64'(wrap1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_decoder_sequencer.md
Name: bin_decoder_sequencer

Overview:
- Parametrised, registered binary-to-one-hot LED decoder. Successor to the fixed 3-to-8 enable-gated decoder.
- Generalises select width to SEL_W bits driving 2**SEL_W outputs.
- Adds a prescaled auto-scan sequencer with up, down and bounce modes, plus a synchronous index load.
- Sits between board switches/buttons and the LED bank.

Parameters:
- SEL_W, 4, select width; outputs = 2**SEL_W; legal range 1..6.
- DIV_MAX, 4, scan prescaler period in clk cycles; legal DIV_MAX >= 1; 1 means step every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  block enable; low blanks led and freezes all state.
- mode  input  2  00 direct, 01 scan up, 10 scan down, 11 bounce.
- ld  input  1  load strobe: idx <= a (scan modes only).
- a  input  SEL_W  direct select / load value.
- led  output  2**SEL_W  registered one-hot output, all-zero when blanked.
- idx  output  SEL_W  current registered index.
- wrap  output  1  one-cycle pulse on sequence wrap/turn-around.

Behaviour:
- Reset (rst_n low at a clk edge): led=0, idx=0, wrap=0, prescaler=0, dir=up, mode_q=00. Reset wins over every other input.
- All state updates on rising clk only. Outputs are registered, with no combinational path from inputs to outputs.
- led encoding: led <= en ? (1 << idx_next) : 0. led and idx always update on the same edge, so led == (1<<idx) whenever en was high at the last edge.
- en low: led <= 0 on the next edge. idx, prescaler, dir and mode_q hold. wrap <= 0.
- Direct mode (00), en high: idx <= a and led <= onehot(a). Latency is one cycle. Prescaler held at 0. ld is ignored.
- Prescaler (scan modes, en high):
  - Counts 0..DIV_MAX-1.
  - tick = (count == DIV_MAX-1); count returns to 0 on tick.
- Scan up (01): on tick, idx <= idx+1. From 2**SEL_W-1 it wraps to 0 and wrap=1 for that cycle.
- Scan down (10): on tick, idx <= idx-1. From 0 it wraps to 2**SEL_W-1 and wrap=1.
- Bounce (11):
  - On tick, idx steps in direction dir.
  - At idx=max with dir=up: dir <= down and idx <= max-1.
  - At idx=0 with dir=down: dir <= up, idx <= 1, wrap=1.
  - Endpoints are never repeated.
  - SEL_W=1: sequence alternates 0,1,0,1.
- ld (scan modes, en high):
  - idx <= a and prescaler <= 0. Overrides a simultaneous tick.
  - No wrap pulse. dir is unchanged.
- Mode change:
  - When mode != mode_q with en high: prescaler <= 0, idx retained, no step that cycle, mode_q <= mode.
  - Entering bounce sets dir=up.
  - ld in the same cycle still loads.
- wrap is 0 in every cycle not listed above.
- Reset mid-scan returns to idx=0, led=0 on that edge. After reset, the first enabled cycle behaves as a mode change if mode != 00.

Decomposition:
- Shared package bin_dec_pkg holds:
  - mode constants MODE_DIRECT=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_BOUNCE=2'b11;
  - a dir_t enum {DIR_UP, DIR_DOWN}.
- One natural sub-module: bin_onehot_dec. It is a combinational, parametrised SEL_W-to-2**SEL_W one-hot decoder with an enable, and is instantiated once on idx_next.
- Prescaler, index/direction logic and output registers stay in the top module.
- Prescaler width = $clog2(DIV_MAX) with a minimum of 1.

Test Plan:
- Reset and direct mode: rst_n=0 for 2 cycles, then rst_n=1, en=1, mode=00, a=4'd9 -> next edge led=16'h0200, idx=9, wrap=0. Then a=4'd0 -> led=16'h0001 one cycle later.
- Scan up with wrap (SEL_W=4, DIV_MAX=3): load a=14 via ld, mode=01 -> idx steps 14,15,0,1 every 3 cycles. wrap=1 for exactly the cycle idx becomes 0; led=16'h0001 then.
- Bounce (DIV_MAX=1), start idx=13 dir=up -> idx 14,15,14,13 on consecutive cycles. Later 2,1,0,1 with wrap=1 only on the 0->1 turn cycle.
- Enable blanking: mid-scan at idx=5, en=0 for 4 cycles -> led=0 and idx stays 5. Prescaler frozen, so after en=1 the step occurs after the remaining count, not a fresh period.
- ld vs tick collision (DIV_MAX=2, mode=10): assert ld with a=3 on a tick cycle -> idx=3, no decrement, no wrap. Next step to 2 occurs exactly 2 cycles later.
- Reset mid-operation: during bounce at idx=8 dir=down, rst_n=0 one cycle -> led=0, idx=0, wrap=0. With mode=11 held, the first enabled cycle is a mode-change (no step); then idx=1 after one period.
